// File: rtl/dds_poly_eval_if.sv
// rtl/dds_poly_eval_if.sv - phase/result handshake and coefficient ROM bus for dds_poly_eval
interface dds_poly_eval_if #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [PHASE_WIDTH-1:0] phase;
    logic                   rom_en;
    logic [ADDR_WIDTH-1:0]  rom_addr;
    logic [DATA_WIDTH-1:0]  coef_a0;
    logic [DATA_WIDTH-1:0]  coef_a1;
    logic [DATA_WIDTH-1:0]  coef_a2;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_data;

    modport slave (
        input  in_valid, phase, coef_a0, coef_a1, coef_a2, out_ready,
        output in_ready, rom_en, rom_addr, out_valid, out_data
    );

    modport master (
        output in_valid, phase, coef_a0, coef_a1, coef_a2, out_ready,
        input  in_ready, rom_en, rom_addr, out_valid, out_data
    );
endinterface

// File: rtl/dds_poly_eval.sv
// rtl/dds_poly_eval.sv - piecewise quadratic evaluator, Horner form on one shared multiplier
module dds_poly_eval #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int X_WIDTH     = 16
) (
    input logic             clk,
    input logic             rst_n,
    dds_poly_eval_if.slave  bus
);
    localparam int PW  = DATA_WIDTH + X_WIDTH + 1;
    localparam int LSB = PHASE_WIDTH - ADDR_WIDTH - X_WIDTH;

    typedef enum logic [2:0] {IDLE, FETCH, H1, H2, OUT} state_t;

    state_t                        state, state_nxt;
    logic [ADDR_WIDTH-1:0]         rom_addr_q;
    logic                          rom_en_q;
    logic [X_WIDTH-1:0]            x_reg;
    logic signed [DATA_WIDTH-1:0]  acc;
    logic [DATA_WIDTH-1:0]         out_data_q;
    logic                          out_valid_q;

    logic signed [DATA_WIDTH-1:0]  mul_a;
    logic signed [DATA_WIDTH-1:0]  addend;
    logic signed [PW-1:0]          prod;
    logic [DATA_WIDTH:0]           sum;
    logic [DATA_WIDTH-1:0]         sat_res;
    logic                          unused_bits;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = FETCH;
            FETCH:   state_nxt = H1;
            H1:      state_nxt = H2;
            H2:      state_nxt = OUT;
            OUT:     if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // H1 multiplies A2, H2 multiplies the running accumulator; x is always the other operand
    always_comb begin
        mul_a   = (state == H1) ? $signed(bus.coef_a2) : acc;
        addend  = (state == H1) ? $signed(bus.coef_a1) : $signed(bus.coef_a0);
        prod    = $signed({{(PW-DATA_WIDTH){mul_a[DATA_WIDTH-1]}}, mul_a})
                * $signed({{(PW-X_WIDTH){1'b0}}, x_reg});
        sum     = {prod[X_WIDTH+DATA_WIDTH-1], prod[X_WIDTH +: DATA_WIDTH]}
                + {addend[DATA_WIDTH-1], addend};
        sat_res = sum[DATA_WIDTH-1:0];
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
            sat_res = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

    assign unused_bits = ^{prod[PW-1], prod[X_WIDTH-1:0], bus.phase[LSB-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q  <= '0;
            rom_en_q    <= 1'b0;
            x_reg       <= '0;
            acc         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        rom_addr_q <= bus.phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
                        x_reg      <= bus.phase[PHASE_WIDTH-ADDR_WIDTH-1 -: X_WIDTH];
                        rom_en_q   <= 1'b1;
                    end
                end
                FETCH: rom_en_q <= 1'b0;
                H1:    acc <= sat_res;
                H2: begin
                    out_data_q  <= sat_res;
                    out_valid_q <= 1'b1;
                end
                OUT:   if (bus.out_ready) out_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.rom_en    = rom_en_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_dds_poly_eval.sv
// tb/tb_dds_poly_eval.sv - scoreboard bench for dds_poly_eval with a registered coefficient ROM model
module tb_dds_poly_eval;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dds_poly_eval_if bus ();
    dds_poly_eval dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    logic [31:0] rom_a0 [32];
    logic [31:0] rom_a1 [32];
    logic [31:0] rom_a2 [32];
    logic [31:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    always @(posedge clk) begin
        if (bus.rom_en) begin
            bus.coef_a0 <= rom_a0[bus.rom_addr];
            bus.coef_a1 <= rom_a1[bus.rom_addr];
            bus.coef_a2 <= rom_a2[bus.rom_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic longint clamp32(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] ph);
        logic [4:0]  seg;
        logic [15:0] xv;
        longint x, t;
        seg = ph[31:27];
        xv  = ph[26:11];
        x   = {48'd0, xv};
        t   = clamp32(((longint'($signed(rom_a2[seg])) * x) >>> 16) + longint'($signed(rom_a1[seg])));
        t   = clamp32(((t * x) >>> 16) + longint'($signed(rom_a0[seg])));
        return t[31:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("sb_unexpected_out", {31'd0, bus.out_valid}, 32'd0);
            else                   check("sb_data", bus.out_data, exp_q.pop_front());
        end
    end

    task automatic load_rom(input logic [31:0] ph, input logic [31:0] a0, a1, a2);
        rom_a0[ph[31:27]] = a0;
        rom_a1[ph[31:27]] = a1;
        rom_a2[ph[31:27]] = a2;
    endtask

    task automatic wait_out(input string tag, output int edges);
        edges = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                edges = k - 1;
                break;
            end
        end
        if (edges < 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_txn(input logic [31:0] ph, input int hold,
                           output logic [31:0] data, output int lat,
                           output int en_cycles, output logic [4:0] addr_seen);
        @(posedge clk); #1;
        bus.phase     = ph;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        exp_q.push_back(model(ph));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = -1; en_cycles = 0; addr_seen = '0; data = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.rom_en) en_cycles++;
            if (k == 1) addr_seen = bus.rom_addr;
            if (bus.out_valid) begin
                lat = k - 1;
                break;
            end
        end
        if (lat < 0) begin
            check("txn_timeout", 32'd0, 32'd1);
            return;
        end
        data = bus.out_data;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("hold_data", bus.out_data, data);
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    logic [31:0] d;
    logic [4:0]  a;
    int          lat, en, e;

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.phase = '0;
        for (int i = 0; i < 32; i++) begin
            rom_a0[i] = '0; rom_a1[i] = '0; rom_a2[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_rom_en",    {31'd0, bus.rom_en},    32'd0);
        check("rst_rom_addr",  {27'd0, bus.rom_addr},  32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data",  bus.out_data,           32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        load_rom(32'h1C000000, 32'h0, 32'h0, 32'h40000000);
        run_txn(32'h1C000000, 0, d, lat, en, a);
        check("basic_addr",    {27'd0, a}, 32'd3);
        check("basic_rom_en",  en,         32'd1);
        check("basic_latency", lat,        32'd3);
        check("basic_data",    d,          32'h10000000);

        load_rom(32'hF8000000, 32'h12345678, 32'h7FFFFFFF, 32'h7FFFFFFF);
        run_txn(32'hF8000000, 1, d, lat, en, a);
        check("x0_addr", {27'd0, a}, 32'd31);
        check("x0_data", d,          32'h12345678);

        load_rom(32'h2FFFF800, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
        run_txn(32'h2FFFF800, 0, d, lat, en, a);
        check("pos_sat_data", d, 32'h7FFFFFFF);

        load_rom(32'h3FFFF800, 32'h80000000, 32'h80000000, 32'h0);
        run_txn(32'h3FFFF800, 0, d, lat, en, a);
        check("neg_sat_acc",  dut.acc, 32'h80000000);
        check("neg_sat_data", d,       32'h80000000);

        load_rom(32'h1C000000, 32'h0, 32'h0, 32'h40000000);
        load_rom(32'h5091A000, 32'h00001000, 32'hFFF00000, 32'h01234567);
        @(posedge clk); #1;
        bus.phase = 32'h1C000000; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        exp_q.push_back(model(32'h1C000000));
        @(posedge clk); #1;
        bus.phase = 32'h5091A000;
        wait_out("bp_first", e);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid",    {31'd0, bus.out_valid}, 32'd1);
            check("bp_data",     bus.out_data,           32'h10000000);
            check("bp_in_ready", {31'd0, bus.in_ready},  32'd0);
            check("bp_rom_en",   {31'd0, bus.rom_en},    32'd0);
            check("bp_rom_addr", {27'd0, bus.rom_addr},  32'd3);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        exp_q.push_back(model(32'h5091A000));
        @(negedge clk);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_idle_ready", {31'd0, bus.in_ready},  32'd1);
        check("bp_idle_valid", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_rom_en", {31'd0, bus.rom_en},   32'd1);
        check("bp_next_addr",   {27'd0, bus.rom_addr}, 32'd10);
        wait_out("bp_second", e);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        @(posedge clk); #1;
        bus.phase = 32'h1C000000; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rom_en",    {31'd0, bus.rom_en},    32'd0);
        check("mid_rst_rom_addr",  {27'd0, bus.rom_addr},  32'd0);
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_out_data",  bus.out_data,           32'd0);
        check("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("mid_rst_acc",       dut.acc,                32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_no_out", {31'd0, bus.out_valid}, 32'd0);
        end
        run_txn(32'h1C000000, 0, d, lat, en, a);
        check("post_rst_data", d, 32'h10000000);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] ph;
            ph = $urandom;
            load_rom(ph, $urandom, $urandom, $urandom);
            run_txn(ph, $urandom_range(0, 2), d, lat, en, a);
            check("rand_latency", lat, 32'd3);
            check("rand_addr",    {27'd0, a}, {27'd0, ph[31:27]});
        end

        repeat (2) @(posedge clk);
        check("sb_drain", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
